// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
//   state_t  : FSM encoding (IDLE/RUN/DONE), 2 bits, code 2'b11 unused
//   sub_ref  : golden (w+1)-bit difference (a - b) mod 2^(w+1), w <= MAX_W
package sub_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [MAX_W:0] sub_ref(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input int w);
    logic [MAX_W:0] d;
    logic [MAX_W:0] mask;
    d    = {1'b0, a} - {1'b0, b};
    mask = ({{MAX_W{1'b0}}, 1'b1} << (w + 1)) - 1'b1;
    return d & mask;
  endfunction

endpackage

// File: rtl/serial_ripple_sub_if.sv
// Operand/result handshake bundle for serial_ripple_sub.
//   in_valid/in_ready/a/b          : operand channel (producer -> block)
//   out_valid/out_ready/result/zero: result channel  (block -> consumer)
// master: producer/consumer side; slave: the subtractor.
interface serial_ripple_sub_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             zero;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, result, zero);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, result, zero);
endinterface

// File: rtl/serial_ripple_sub_full_sub.sv
// One-bit full subtractor: a - b - borrow_in.
//   diff       : difference bit
//   borrow_out : borrow into the next more significant bit
// Two half-subtractor stages joined by an OR, same shape as the full_add cell.
module full_sub (
  output logic diff,
  output logic borrow_out,
  input  logic borrow_in,
  input  logic a,
  input  logic b
);
  logic d1, b1, b2;

  assign d1         = a ^ b;
  assign b1         = ~a & b;
  assign diff       = d1 ^ borrow_in;
  assign b2         = ~d1 & borrow_in;
  assign borrow_out = b1 | b2;
endmodule

// File: rtl/serial_ripple_sub.sv
// Bit-serial two's-complement subtractor: result = (a - b) mod 2^(WIDTH+1),
// one bit per clock through a single full_sub cell and a registered borrow.
//   clk, rst_n : clock, async active-low reset
//   bus        : serial_ripple_sub_if slave (operand in, result out)
// Operands are captured on acceptance; out_valid rises WIDTH edges later and
// the result is held until taken. result[WIDTH] is the final borrow (b > a).
module serial_ripple_sub
  import sub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_ripple_sub_if.slave   bus
);

  state_t           st, st_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, diff;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   res_q;
  logic             zero_q, ov_q;
  logic             d, bout;
  logic             accept, fire, last;
  logic [WIDTH:0]   res_nxt;

  full_sub u_cell (
    .diff       (d),
    .borrow_out (bout),
    .borrow_in  (borrow),
    .a          (a_sr[0]),
    .b          (b_sr[0])
  );

  assign last    = (st == RUN) && (cnt == CW'(WIDTH - 1));
  // Final word includes the bit being produced on this edge.
  assign res_nxt = {bout, d, diff[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  // Next-state logic; unused code 2'b11 falls back to IDLE
  always_comb begin
    st_nxt = IDLE;
    case (st)
      IDLE:    st_nxt = bus.in_valid ? RUN : IDLE;
      RUN:     st_nxt = last ? DONE : RUN;
      DONE:    st_nxt = (ov_q && bus.out_ready) ? IDLE : DONE;
      default: st_nxt = IDLE;
    endcase
  end

  // Output / handshake decode
  always_comb begin
    bus.in_ready  = (st == IDLE);
    accept        = bus.in_valid && (st == IDLE);
    fire          = ov_q && bus.out_ready && (st == DONE);
    bus.out_valid = ov_q;
    bus.result    = res_q;
    bus.zero      = zero_q;
  end

  // Datapath: shift registers, borrow flop, counter, result holding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      ov_q   <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      diff   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (st == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      diff   <= {d, diff[WIDTH-1:1]};
      borrow <= bout;
      cnt    <= cnt + CW'(1);
      if (last) begin
        res_q  <= res_nxt;
        zero_q <= (res_nxt == '0);
        ov_q   <= 1'b1;
      end
    end else if (fire) begin
      ov_q <= 1'b0;
    end
  end

endmodule

// File: doc/serial_ripple_sub.md
Name: serial_ripple_sub

Overview:
- Bit-serial two's-complement subtractor, the inverse companion to the combinational ripple-carry adder.
- Computes A − B one bit per clock. It uses a single full-subtractor cell and a registered borrow, so the borrow ripples through time instead of through a gate chain.
- Area-cheap arithmetic for non-critical paths.
- Operands enter through a valid/ready handshake. The (WIDTH+1)-bit result leaves through a second valid/ready handshake.

Parameters:
- WIDTH, 8, operand width in bits; legal range ≥2.
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH+1  A − B in two's complement; result[WIDTH] is the final borrow.
- zero  output  1  result == 0, qualified by out_valid.

Behaviour:
- Interface (decided): one clock, clk. Reset rst_n is asynchronous and active-low. All flops clear immediately on rst_n low, independent of clk.
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, borrow register=0, counter=0, shift registers=0.
- in_ready is combinational: (state==IDLE). It reads 1 during reset, but inputs are ignored while rst_n=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On in_valid&&in_ready: load a_sr=a, b_sr=b, borrow=0, cnt=0 → RUN.
  - a/b are sampled only on this edge; later input changes have no effect.
- RUN, each edge:
  - Bit cell computes d = a0^b0^bin and bout = (~a0&b0)|(~(a0^b0)&bin), where a0=a_sr[0], b0=b_sr[0], bin=borrow.
  - d shifts into the MSB of the difference register; a_sr and b_sr shift right; borrow<=bout; cnt++.
  - On the edge where cnt==WIDTH-1: result<={bout, diff}, zero<=({bout,diff}==0), out_valid<=1 → DONE.
- Latency: out_valid rises exactly WIDTH clock edges after the acceptance edge.
- DONE:
  - result, zero and out_valid are held stable until out_valid&&out_ready.
  - On that edge: out_valid<=0 → IDLE. result holds its last value; it is not cleared.
- No overlap: in_ready=0 in RUN and DONE. Minimum period per operation is WIDTH+2 cycles.
- Width rule: result equals (a − b) mod 2^(WIDTH+1). result[WIDTH]=1 iff b>a. No overflow is possible.
- in_valid while busy: ignored; the producer must hold it.
- out_ready asserted outside DONE: ignored.
- Reset mid-RUN or mid-DONE: the operation is dropped silently, out_valid falls asynchronously, and there is no partial result. The first transaction after reset release is computed correctly.
- No X propagation: the counter and the state register are fully encoded, and illegal state encodings recover to IDLE.

Decomposition:
- Shared package sub_pkg holds:
  - state enum {IDLE, RUN, DONE}.
  - Function sub_ref(a, b) returning the (WIDTH+1)-bit golden difference, for the bench.
- One sub-module: full_sub (ports diff, borrow_out, borrow_in, a, b), purely combinational. It mirrors the existing full_add cell and is built from two half-subtractor stages plus an OR.
- Top level holds the FSM, counter, shift registers and borrow flop.

Test Plan:
- a=8'hAD, b=8'h39, out_ready=1 → out_valid exactly 8 edges after accept; result=9'h074, zero=0; next edge in_ready=1.
- a=8'h39, b=8'hAD → result=9'h18C (borrow=1, low byte 8'h8C); a=8'h00, b=8'h01 → 9'h1FF.
- a=b=8'h55 → result=9'h000, zero=1; a=8'hFF, b=8'h00 → 9'h0FF, zero=0.
- Backpressure: after 8'hAD−8'h39, hold out_ready=0 for 5 cycles → result stays 9'h074, out_valid=1, in_ready=0; a/b toggled meanwhile are ignored; release → IDLE.
- Reset: pulse rst_n low for half a cycle 3 edges into RUN → out_valid=0 and state IDLE immediately; then 8'h10−8'h01 → 9'h00F.
- WIDTH=4 instance: a=4'h3, b=4'h5 → result=5'h1E after 4 edges; 1000 random pairs checked against sub_ref.
